fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Parametrised instruction-fetch front end. Merges PC register, PC incrementer and instruction reader into one block.
- Adds a prefetch FIFO between fetch and decode, with back-pressure from decode, arbitration loss on the shared memory port, and branch redirect/flush.
- Sits between the instruction memory port and the decoder/forwarder stage of cpu.

Parameters:
- ADDR_W, 16, PC / memory address width
- INSTR_W, 16, instruction word width
- DEPTH, 4, prefetch FIFO entries (power of two, >=2)
- RESET_PC, 0, fetch address after reset

Ports:
- clk, input, 1, clock (rising edge)
- rst, input, 1, asynchronous reset, active-high
- mem_addr, output, ADDR_W, instruction fetch address
- mem_req, output, 1, fetch request this cycle
- mem_grant, input, 1, port granted this cycle (0 = stolen by data access)
- mem_rdata, input, INSTR_W, read data, valid the cycle after a granted request
- redirect, input, 1, branch/jump taken: flush and refetch
- redirect_pc, input, ADDR_W, new fetch address
- deq, input, 1, decoder consumes head entry
- out_valid, output, 1, head entry valid
- out_ir, output, INSTR_W, head instruction
- out_pc, output, ADDR_W, address of head instruction
- count, output, $clog2(DEPTH)+1, occupied entries

Behaviour:
- Reset (async, immediate):
  - fetch_pc=RESET_PC; FIFO empty; inflight=0.
  - Outputs: out_valid=0, out_ir=0, out_pc=0, count=0, mem_req=0.
  - mem_addr=RESET_PC.
- Request rule (combinational):
  - mem_req=1 iff !rst && !redirect && (count+inflight < DEPTH). A deq in the same cycle is not credited.
  - mem_addr=fetch_pc.
- Granted request (mem_req && mem_grant at edge N):
  - inflight<=1; pend_pc<=fetch_pc; fetch_pc<=fetch_pc+1, modulo 2^ADDR_W (0xFFFF wraps to 0x0000).
  - Not granted: fetch_pc holds; request repeats next cycle.
- Response: if inflight=1 in cycle N+1, push {mem_rdata, pend_pc} into the FIFO at edge N+1 and clear inflight, unless a new grant sets it again.
  - At most one request is in flight; back-to-back grants give one instruction per cycle.
- Latency: grant in cycle N -> out_valid visible in cycle N+2 when FIFO was empty. There is no bypass.
- Dequeue: when deq && out_valid, pop at edge. deq while !out_valid is ignored; it never underflows.
- Push and pop in the same cycle: count unchanged, allowed when full.
- Full: the request rule prevents overflow. A push into a full FIFO cannot occur; assert this in simulation.
- Redirect (priority over all other events) at edge:
  - FIFO cleared, count=0, fetch_pc<=redirect_pc.
  - An in-flight response arriving in the following cycle is discarded. Implement with an epoch bit toggled on redirect and captured with each request.
  - mem_req=0 during the redirect cycle; the first request to redirect_pc is issued the next cycle.
- Redirect + deq same cycle: redirect wins; the pop is a no-op.
- Redirect while empty and idle: only fetch_pc changes.
- Outputs: out_ir/out_pc are driven from the FIFO head register. When empty they hold their last value; consumers qualify them with out_valid.

Decomposition:
- Package cpu_pkg holds the ADDR_W/INSTR_W defaults and the RESET_PC default constant.
- Sub-module fetch_fifo: generic synchronous FIFO (width, depth), with push/pop/clear/count, async reset, and wrap-around read/write pointers plus an extra count bit.
- fetch_queue contains the PC register, incrementer, inflight/epoch tracking and request logic.

Test Plan:
- Reset release, mem_grant=1, deq=0, DEPTH=4:
  - mem_addr runs 0,1,2,3; mem_req drops when count+inflight=4.
  - count=4; out_pc=0; out_ir=mem[0].
- Steady stream, deq=1 every cycle, grant=1: after a 2-cycle fill, out_pc increments by 1 each cycle, with no gaps and no duplicates.
- mem_grant=0 for 3 cycles mid-stream: mem_addr holds (e.g. 5) for 3 cycles; the FIFO drains; fetch resumes at 5 with no skipped PC.
- redirect=1, redirect_pc=0x0040, with a response in flight for PC 7:
  - Next cycle count=0 and out_valid=0; the PC 7 data is discarded.
  - First request is at 0x0040; out_pc=0x0040 two cycles after its grant.
- Wrap: redirect_pc=0xFFFE, grant=1: fetched PCs are 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Async reset asserted mid-stream with count=3: all outputs are reset values immediately, before the next edge. After release, mem_addr=RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants used by the fetch front end.
//   DefAddrW  : default PC / instruction-memory address width
//   DefInstrW : default instruction word width
//   DefResetPc: default fetch address after reset
package cpu_pkg;

  localparam int unsigned DefAddrW  = 16;
  localparam int unsigned DefInstrW = 16;
  localparam logic [DefAddrW-1:0] DefResetPc = 16'h0000;

  // Width of an occupancy counter that can represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with a registered head output.
//   clk, rst  : clock, asynchronous active-high reset
//   push_i    : write wdata_i at the tail
//   pop_i     : drop the head entry (ignored when empty)
//   clear_i   : empty the FIFO; wins over push and pop
//   wdata_i   : tail write data
//   rdata_o   : head entry; holds its last value while empty
//   valid_o   : FIFO not empty
//   count_o   : occupied entries (0..Depth)
module fetch_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     clear_i,
  input  logic [Width-1:0]         wdata_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     valid_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW:0]    wr_q, wr_d, rd_q, rd_d;
  logic [Width-1:0] head_q, head_d;
  logic             empty, full, push_eff, pop_eff;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count_o  = wr_q - rd_q;
  assign empty    = (count_o == '0);
  assign full     = (count_o == (PtrW+1)'(Depth));
  assign push_eff = push_i && !clear_i;
  assign pop_eff  = pop_i && !empty && !clear_i;

  assign valid_o = !empty;
  assign rdata_o = head_q;

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    head_d = head_q;
    if (clear_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push_eff) wr_d = wr_q + (PtrW+1)'(1);
      if (pop_eff)  rd_d = rd_q + (PtrW+1)'(1);
      // head_q mirrors mem_q[rd_q] while non-empty; an entry being written this
      // edge is not in the array yet, so it is forwarded from wdata_i.
      if (pop_eff) begin
        if (count_o == (PtrW+1)'(1)) begin
          if (push_eff) head_d = wdata_i;
        end else begin
          head_d = mem_q[rd_d[PtrW-1:0]];
        end
      end else if (empty && push_eff) begin
        head_d = wdata_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      head_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      head_q <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_eff) mem_q[wr_q[PtrW-1:0]] <= wdata_i;
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(push_eff && full && !pop_eff))
        else $error("fetch_fifo: push into a full FIFO");
    end
  end
`endif

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC register, incrementer, single-outstanding
// memory reader and a prefetch FIFO towards decode.
//   clk, rst      : clock, asynchronous active-high reset
//   mem_addr      : fetch address (current fetch PC)
//   mem_req       : fetch request this cycle
//   mem_grant     : memory port granted (0 = taken by a data access)
//   mem_rdata     : read data, valid the cycle after a granted request
//   redirect      : taken branch/jump; flush queue and refetch
//   redirect_pc   : new fetch address
//   deq           : decoder consumes head entry
//   out_valid     : head entry valid
//   out_ir/out_pc : head instruction and its address
//   count         : occupied FIFO entries
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = DefAddrW,
  parameter int unsigned       INSTR_W  = DefInstrW,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DefResetPc)
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_req,
  input  logic                     mem_grant,
  input  logic [INSTR_W-1:0]       mem_rdata,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  input  logic                     deq,
  output logic                     out_valid,
  output logic [INSTR_W-1:0]       out_ir,
  output logic [ADDR_W-1:0]        out_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned CntW = cnt_width(DEPTH);
  localparam int unsigned EntW = ADDR_W + INSTR_W;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic              inflight_q, inflight_d;
  logic              epoch_q, epoch_d;
  logic              req_epoch_q, req_epoch_d;

  logic [CntW:0]     occupancy;
  logic              grant, push, pop;
  logic [EntW-1:0]   fifo_wdata, fifo_rdata;

  // Reserve a slot for the outstanding response; a same-cycle deq is not
  // credited so the request path never depends on the decoder.
  assign occupancy = {1'b0, count} + {{CntW{1'b0}}, inflight_q};
  assign mem_req   = !rst && !redirect && (occupancy < (CntW+1)'(DEPTH));
  assign mem_addr  = fetch_pc_q;
  assign grant     = mem_req && mem_grant;

  // A response tagged with a stale epoch belongs to a flushed path.
  assign push = inflight_q && (req_epoch_q == epoch_q) && !redirect;
  assign pop  = deq && !redirect;

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    pend_pc_d   = pend_pc_q;
    inflight_d  = grant;
    epoch_d     = epoch_q;
    req_epoch_d = req_epoch_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      epoch_d    = !epoch_q;
    end else if (grant) begin
      fetch_pc_d  = fetch_pc_q + ADDR_W'(1);
      pend_pc_d   = fetch_pc_q;
      req_epoch_d = epoch_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q  <= RESET_PC;
      pend_pc_q   <= '0;
      inflight_q  <= 1'b0;
      epoch_q     <= 1'b0;
      req_epoch_q <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      pend_pc_q   <= pend_pc_d;
      inflight_q  <= inflight_d;
      epoch_q     <= epoch_d;
      req_epoch_q <= req_epoch_d;
    end
  end

  assign fifo_wdata = {mem_rdata, pend_pc_q};

  fetch_fifo #(
    .Width (EntW),
    .Depth (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (redirect),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata),
    .valid_o (out_valid),
    .count_o (count)
  );

  assign out_pc = fifo_rdata[ADDR_W-1:0];
  assign out_ir = fifo_rdata[ADDR_W +: INSTR_W];

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] mem_addr;
  logic        mem_req;
  logic        mem_grant = 1'b0;
  logic [15:0] mem_rdata;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic        deq = 1'b0;
  logic        out_valid;
  logic [15:0] out_ir;
  logic [15:0] out_pc;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_queue #(
    .ADDR_W   (16),
    .INSTR_W  (16),
    .DEPTH    (4),
    .RESET_PC (16'h0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_addr    (mem_addr),
    .mem_req     (mem_req),
    .mem_grant   (mem_grant),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .deq         (deq),
    .out_valid   (out_valid),
    .out_ir      (out_ir),
    .out_pc      (out_pc),
    .count       (count)
  );

  // Instruction memory: word at address A is A ^ 16'h5A00, returned the
  // cycle after a granted request.
  logic [15:0] rd_addr = 16'h0;
  always @(posedge clk) begin
    if (mem_req && mem_grant) rd_addr <= mem_addr;
  end
  assign mem_rdata = rd_addr ^ 16'h5A00;

  function automatic logic [15:0] word_at(input logic [15:0] a);
    return a ^ 16'h5A00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        grant;
    logic        deq;
    logic        redir;
    logic [15:0] rpc;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_valid;
    logic [2:0]  e_cnt;
    logic [15:0] e_pc;
  } vec_t;

  localparam int NV = 29;
  vec_t vecs [NV];

  function automatic vec_t v(input logic g, input logic d, input logic r, input logic [15:0] rp,
                             input logic er, input logic [15:0] ea, input logic ev,
                             input logic [2:0] ec, input logic [15:0] ep);
    vec_t x;
    x.grant = g; x.deq = d; x.redir = r; x.rpc = rp;
    x.e_req = er; x.e_addr = ea; x.e_valid = ev; x.e_cnt = ec; x.e_pc = ep;
    return x;
  endfunction

  initial begin
    //               grant deq redir rpc       req addr      valid cnt pc
    // fill from reset, no dequeue
    vecs[0]  = v(1, 0, 0, 16'h0000, 1, 16'h0000, 0, 0, 16'h0000);
    vecs[1]  = v(1, 0, 0, 16'h0000, 1, 16'h0001, 0, 0, 16'h0000);
    vecs[2]  = v(1, 0, 0, 16'h0000, 1, 16'h0002, 1, 1, 16'h0000);
    vecs[3]  = v(1, 0, 0, 16'h0000, 1, 16'h0003, 1, 2, 16'h0000);
    vecs[4]  = v(1, 0, 0, 16'h0000, 0, 16'h0004, 1, 3, 16'h0000);
    vecs[5]  = v(1, 0, 0, 16'h0000, 0, 16'h0004, 1, 4, 16'h0000);
    // steady stream with dequeue every cycle
    vecs[6]  = v(1, 1, 0, 16'h0000, 0, 16'h0004, 1, 4, 16'h0000);
    vecs[7]  = v(1, 1, 0, 16'h0000, 1, 16'h0004, 1, 3, 16'h0001);
    vecs[8]  = v(1, 1, 0, 16'h0000, 1, 16'h0005, 1, 2, 16'h0002);
    // grant stolen for 3 cycles: address holds at 6, queue drains
    vecs[9]  = v(0, 1, 0, 16'h0000, 1, 16'h0006, 1, 2, 16'h0003);
    vecs[10] = v(0, 1, 0, 16'h0000, 1, 16'h0006, 1, 2, 16'h0004);
    vecs[11] = v(0, 1, 0, 16'h0000, 1, 16'h0006, 1, 1, 16'h0005);
    // resume at 6; deq on empty queue is ignored
    vecs[12] = v(1, 1, 0, 16'h0000, 1, 16'h0006, 0, 0, 16'h0000);
    vecs[13] = v(1, 1, 0, 16'h0000, 1, 16'h0007, 0, 0, 16'h0000);
    // redirect + deq with PC 7 in flight: flush, PC 7 discarded
    vecs[14] = v(1, 1, 1, 16'h0040, 0, 16'h0008, 1, 1, 16'h0006);
    vecs[15] = v(1, 0, 0, 16'h0000, 1, 16'h0040, 0, 0, 16'h0000);
    vecs[16] = v(1, 0, 0, 16'h0000, 1, 16'h0041, 0, 0, 16'h0000);
    // 0x40 visible two cycles after its grant; redirect to wrap region
    vecs[17] = v(1, 0, 1, 16'hFFFE, 0, 16'h0042, 1, 1, 16'h0040);
    vecs[18] = v(1, 1, 0, 16'h0000, 1, 16'hFFFE, 0, 0, 16'h0000);
    vecs[19] = v(1, 1, 0, 16'h0000, 1, 16'hFFFF, 0, 0, 16'h0000);
    vecs[20] = v(1, 1, 0, 16'h0000, 1, 16'h0000, 1, 1, 16'hFFFE);
    vecs[21] = v(1, 1, 0, 16'h0000, 1, 16'h0001, 1, 1, 16'hFFFF);
    vecs[22] = v(1, 1, 0, 16'h0000, 1, 16'h0002, 1, 1, 16'h0000);
    vecs[23] = v(1, 1, 0, 16'h0000, 1, 16'h0003, 1, 1, 16'h0001);
    // redirect to 0x10 then fill to count=3 for the async reset check
    vecs[24] = v(1, 0, 1, 16'h0010, 0, 16'h0004, 1, 1, 16'h0002);
    vecs[25] = v(1, 0, 0, 16'h0000, 1, 16'h0010, 0, 0, 16'h0000);
    vecs[26] = v(1, 0, 0, 16'h0000, 1, 16'h0011, 0, 0, 16'h0000);
    vecs[27] = v(1, 0, 0, 16'h0000, 1, 16'h0012, 1, 1, 16'h0010);
    vecs[28] = v(1, 0, 0, 16'h0000, 1, 16'h0013, 1, 2, 16'h0010);

    // reset state
    #1;
    chk("rst mem_req",   32'(mem_req),   32'h0);
    chk("rst mem_addr",  32'(mem_addr),  32'h0);
    chk("rst out_valid", 32'(out_valid), 32'h0);
    chk("rst out_ir",    32'(out_ir),    32'h0);
    chk("rst out_pc",    32'(out_pc),    32'h0);
    chk("rst count",     32'(count),     32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      mem_grant   = vecs[i].grant;
      deq         = vecs[i].deq;
      redirect    = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
      #1;
      chk($sformatf("row%0d mem_req", i),   32'(mem_req),   32'(vecs[i].e_req));
      chk($sformatf("row%0d mem_addr", i),  32'(mem_addr),  32'(vecs[i].e_addr));
      chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
      chk($sformatf("row%0d count", i),     32'(count),     32'(vecs[i].e_cnt));
      if (vecs[i].e_valid) begin
        chk($sformatf("row%0d out_pc", i), 32'(out_pc), 32'(vecs[i].e_pc));
        chk($sformatf("row%0d out_ir", i), 32'(out_ir), 32'(word_at(vecs[i].e_pc)));
      end
      @(posedge clk);
      #1;
    end

    // async reset mid-stream with three entries queued
    redirect = 1'b0;
    deq      = 1'b0;
    #1;
    chk("pre-reset count",   32'(count),   32'h3);
    chk("pre-reset mem_req", 32'(mem_req), 32'h0);
    #1;
    rst = 1'b1;
    #1;
    chk("async rst out_valid", 32'(out_valid), 32'h0);
    chk("async rst out_ir",    32'(out_ir),    32'h0);
    chk("async rst out_pc",    32'(out_pc),    32'h0);
    chk("async rst count",     32'(count),     32'h0);
    chk("async rst mem_req",   32'(mem_req),   32'h0);
    chk("async rst mem_addr",  32'(mem_addr),  32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post-rst mem_addr", 32'(mem_addr), 32'h0);
    chk("post-rst mem_req",  32'(mem_req),  32'h1);
    mem_grant = 1'b0;
    @(posedge clk);
    #1;

    // redirect while empty and idle: only the fetch PC moves
    redirect    = 1'b1;
    redirect_pc = 16'h0020;
    #1;
    chk("idle redir mem_req", 32'(mem_req), 32'h0);
    @(posedge clk);
    #1;
    redirect = 1'b0;
    #1;
    chk("idle redir mem_addr",  32'(mem_addr),  32'h0020);
    chk("idle redir count",     32'(count),     32'h0);
    chk("idle redir out_valid", 32'(out_valid), 32'h0);

    // grant at 0x20, visible two cycles later
    mem_grant = 1'b1;
    #1;
    chk("lat mem_req", 32'(mem_req), 32'h1);
    @(posedge clk);
    #1;
    chk("lat +1 out_valid", 32'(out_valid), 32'h0);
    chk("lat +1 mem_addr",  32'(mem_addr),  32'h0021);
    @(posedge clk);
    #1;
    chk("lat +2 out_valid", 32'(out_valid), 32'h1);
    chk("lat +2 out_pc",    32'(out_pc),    32'h0020);
    chk("lat +2 out_ir",    32'(out_ir),    32'(word_at(16'h0020)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
